// File: rtl/noc_ni_injector.sv
// Network-interface injector: turns (dest, len) requests plus a payload stream into
// header/payload flits for the router's local FIFO, gated by a credit counter. Optional macro: NI_CHECKSUM_EN.
module noc_ni_injector #(
   parameter int CREDITS = 8,
   parameter int ADDR_W  = 4,
   parameter int LEN_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_dest,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [7:0]        pl_data,
   input  logic              pl_valid,
   output logic              pl_ready,
   output logic [7:0]        flit_out,
   output logic              flit_wr,
   input  logic              credit_ret,
   output logic [3:0]        credit_cnt,
   output logic              busy,
   output logic              credit_err
);

   localparam int CW = $clog2(CREDITS + 1);

`ifdef NI_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, HEAD, BODY, CSUM} state_t;
   localparam state_t DONE_ST = CSUM;
`else
   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
   localparam state_t DONE_ST = IDLE;
`endif

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] dest_reg, dest_next;
   logic [LEN_W-1:0]  len_reg, len_next;
   logic [LEN_W-1:0]  remaining_reg, remaining_next;
   logic [CW-1:0]     credit_reg;
   logic [7:0]        flit_reg;
   logic              wr_reg;
   logic              err_reg;
   logic              send;
   logic [7:0]        send_data;
   logic              have_credit;
`ifdef NI_CHECKSUM_EN
   logic [7:0]        csum_reg;
`endif

   assign have_credit = (credit_reg != '0);

   always_comb begin
      state_next     = state_reg;
      dest_next      = dest_reg;
      len_next       = len_reg;
      remaining_next = remaining_reg;
      send           = 1'b0;
      send_data      = '0;
      req_ready      = 1'b0;
      pl_ready       = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               dest_next      = req_dest;
               len_next       = req_len;
               remaining_next = req_len;
               state_next     = HEAD;
            end
         end
         HEAD: begin
            if (have_credit) begin
               send       = 1'b1;
               send_data  = 8'({dest_reg, len_reg});
               state_next = (len_reg != '0) ? BODY : DONE_ST;
            end
         end
         BODY: begin
            pl_ready = have_credit;
            if (pl_valid && have_credit) begin
               send           = 1'b1;
               send_data      = pl_data;
               remaining_next = (remaining_reg != '0) ? remaining_reg - LEN_W'(1) : '0;
               if (remaining_reg <= LEN_W'(1))
                  state_next = DONE_ST;
            end
         end
`ifdef NI_CHECKSUM_EN
         CSUM: begin
            if (have_credit) begin
               send       = 1'b1;
               send_data  = csum_reg;
               state_next = IDLE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         dest_reg      <= '0;
         len_reg       <= '0;
         remaining_reg <= '0;
         flit_reg      <= '0;
         wr_reg        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         dest_reg      <= dest_next;
         len_reg       <= len_next;
         remaining_reg <= remaining_next;
         wr_reg        <= send;
         if (send)
            flit_reg <= send_data;
      end
   end

   // A send and a returned credit in the same cycle cancel; an unmatched return at full count is an error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_reg <= CW'(CREDITS);
         err_reg    <= 1'b0;
      end else begin
         case ({send, credit_ret})
            2'b10: credit_reg <= credit_reg - CW'(1);
            2'b01: begin
               if (credit_reg == CW'(CREDITS))
                  err_reg <= 1'b1;
               else
                  credit_reg <= credit_reg + CW'(1);
            end
            default: credit_reg <= credit_reg;
         endcase
      end
   end

`ifdef NI_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         csum_reg <= '0;
      else if (state_reg == IDLE)
         csum_reg <= '0;
      else if (send)
         csum_reg <= csum_reg ^ send_data;
   end
`endif

   assign flit_out   = flit_reg;
   assign flit_wr    = wr_reg;
   assign credit_cnt = 4'(credit_reg);
   assign busy       = (state_reg != IDLE);
   assign credit_err = err_reg;

endmodule
